// File: rtl/ssd_ctrl_pkg.sv
// Shared types and constants for the flash-channel RAM arbiter slice.
// Channel count is tied to the 4-bit select of the ram_ch output-enable mux.
package ssd_ctrl_pkg;

    localparam int NUM_CH       = 16;
    localparam int CH_W         = 4;
    localparam int BURST_W      = 10;
    localparam int TIMEOUT_DFLT = 1023;

    typedef logic [BURST_W-1:0] burst_len_t;
    typedef logic [CH_W-1:0]    ch_idx_t;
    typedef logic [NUM_CH-1:0]  ch_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    function automatic ch_vec_t ch_onehot(input ch_idx_t ch);
        return ch_vec_t'(1) << ch;
    endfunction

endpackage

// File: rtl/ram_ch_arb_if.sv
// Channel-side bundle of the RAM read-port arbiter.
// The arbiter is the slave; the channels/RAM mux side is the master.
interface ram_ch_arb_if;
    import ssd_ctrl_pkg::*;

    // Handshake: ch_req[i] is a level request (valid) held by channel i for as
    // long as it wants the port; ch_gnt[i] (ready) is registered, one-hot, and
    // rises one cycle after the arbiter samples the request in IDLE. A channel
    // may drop its request at any time; doing so while granted ends the burst.
    // Each high cycle of ram_oe_sel during a grant is exactly one data beat.
    ch_vec_t    ch_req;
    burst_len_t burst_len;
    logic       ram_oe_sel;
    ch_idx_t    ch_num;
    ch_vec_t    ch_gnt;
    logic       busy;
    burst_len_t beat_cnt;
    logic       timeout_err;
    arb_state_t dbg_state;

    modport master (
        output ch_req,
        output burst_len,
        output ram_oe_sel,
        input  ch_num,
        input  ch_gnt,
        input  busy,
        input  beat_cnt,
        input  timeout_err,
        input  dbg_state
    );

    modport slave (
        input  ch_req,
        input  burst_len,
        input  ram_oe_sel,
        output ch_num,
        output ch_gnt,
        output busy,
        output beat_cnt,
        output timeout_err,
        output dbg_state
    );

endinterface

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first requesting channel found searching
// upward from i_last_ptr+1 (mod 16), so the last owner is considered last.
module rr_pick16
    import ssd_ctrl_pkg::*;
(
    input  ch_vec_t i_req,
    input  ch_idx_t i_last_ptr,
    output ch_idx_t o_winner,
    output logic    o_valid
);

    ch_idx_t w_idx;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        // Offset NUM_CH wraps to i_last_ptr itself, the lowest priority slot.
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = i_last_ptr + CH_W'(i);
            if (!o_valid && i_req[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_ch_arb.sv
// Round-robin owner of the shared page-buffer RAM read port across 16 flash
// channels, with burst beat counting and a stall watchdog.
module ram_ch_arb
    import ssd_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_ch_arb_if.slave  bus
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_t  r_state;
    ch_idx_t     r_last_ptr;
    ch_idx_t     r_ch_num;
    ch_vec_t     r_ch_gnt;
    logic        r_busy;
    burst_len_t  r_beat_cnt;
    burst_len_t  r_len_q;
    logic [WD_W-1:0] r_wd_cnt;
    logic        r_timeout_err;

    ch_idx_t     w_winner;
    logic        w_valid;
    logic        w_beat;
    burst_len_t  w_last_idx;
    logic        w_final;
    logic        w_abort;
    logic        w_wd_hit;
    logic        w_release;

    rr_pick16 u_pick (
        .i_req      (bus.ch_req),
        .i_last_ptr (r_last_ptr),
        .o_winner   (w_winner),
        .o_valid    (w_valid)
    );

    // len_q of zero wraps to all-ones here, giving a 2^BURST_W-beat burst.
    assign w_beat     = bus.ram_oe_sel;
    assign w_last_idx = r_len_q - burst_len_t'(1);
    assign w_final    = w_beat && (r_beat_cnt == w_last_idx);
    assign w_abort    = !bus.ch_req[r_ch_num];
    assign w_wd_hit   = !w_beat && (r_wd_cnt == WD_W'(TIMEOUT - 1));
    assign w_release  = w_final || w_abort || w_wd_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_ptr    <= ch_idx_t'(NUM_CH - 1);
            r_ch_num      <= '0;
            r_ch_gnt      <= '0;
            r_busy        <= 1'b0;
            r_beat_cnt    <= '0;
            r_len_q       <= '0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state    <= ST_GRANT;
                        r_ch_num   <= w_winner;
                        r_ch_gnt   <= ch_onehot(w_winner);
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                        r_len_q    <= bus.burst_len;
                        r_wd_cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + burst_len_t'(1);
                        r_wd_cnt   <= '0;
                    end else if (r_wd_cnt != WD_W'(TIMEOUT)) begin
                        r_wd_cnt   <= r_wd_cnt + WD_W'(1);
                    end
                    // Final beat outranks a request drop, which outranks the watchdog.
                    if (w_release) begin
                        r_state       <= ST_RELEASE;
                        r_ch_gnt      <= '0;
                        r_busy        <= 1'b0;
                        r_last_ptr    <= r_ch_num;
                        r_timeout_err <= !w_final && !w_abort && w_wd_hit;
                    end
                end
                ST_RELEASE: begin
                    r_state  <= ST_IDLE;
                    r_wd_cnt <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ch_num      = r_ch_num;
    assign bus.ch_gnt      = r_ch_gnt;
    assign bus.busy        = r_busy;
    assign bus.beat_cnt    = r_beat_cnt;
    assign bus.timeout_err = r_timeout_err;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_ram_ch_arb.sv
// Bench for ram_ch_arb: directed scenarios plus random traffic, checked every
// cycle against a transaction-level owner/beat model.
module tb_ram_ch_arb;

    localparam int TIMEOUT = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ram_ch_arb_if bus ();

    ram_ch_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [15:0] prev_gnt = '0;

    // ---------------- behavioural model ----------------
    int m_owner = -1;   // -1: nobody owns the port
    int m_last  = 15;
    int m_num   = 0;
    int m_beats = 0;
    int m_len   = 1;
    int m_idle  = 0;
    bit m_rel   = 0;
    bit m_terr  = 0;

    always @(posedge clk or negedge rst_n) begin
        bit done, drop, tmo, found;
        int c;
        if (!rst_n) begin
            m_owner = -1; m_last = 15; m_num = 0; m_beats = 0;
            m_len = 1; m_idle = 0; m_rel = 0; m_terr = 0;
        end else begin
            m_terr = 0;
            if (m_rel) begin
                m_rel = 0;
            end else if (m_owner < 0) begin
                found = 0;
                for (int k = 1; k <= 16; k++) begin
                    c = (m_last + k) % 16;
                    if (!found && bus.ch_req[c]) begin
                        found   = 1;
                        m_owner = c;
                        m_num   = c;
                        m_beats = 0;
                        m_idle  = 0;
                        m_len   = (bus.burst_len == 0) ? 1024 : int'(bus.burst_len);
                    end
                end
            end else begin
                done = bus.ram_oe_sel && (m_beats + 1 == m_len);
                if (bus.ram_oe_sel) begin
                    m_beats++;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
                drop = !bus.ch_req[m_owner];
                tmo  = (m_idle >= TIMEOUT);
                if (done || drop || tmo) begin
                    m_terr  = !done && !drop && tmo;
                    m_last  = m_owner;
                    m_owner = -1;
                    m_rel   = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- per-cycle compare + grant monitor ----------------
    always @(negedge clk) begin
        check("ch_num", 32'(bus.ch_num), 32'(m_num));
        check("ch_gnt", 32'(bus.ch_gnt), (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
        check("busy", 32'(bus.busy), 32'(m_owner >= 0));
        check("beat_cnt", 32'(bus.beat_cnt), 32'(m_beats % 1024));
        check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
        check("gnt_onehot0", 32'($onehot0(bus.ch_gnt)), 32'h1);
        if (bus.ch_gnt != 0 && prev_gnt == 0) got_q.push_back(bus.ch_num);
        prev_gnt = bus.ch_gnt;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.ch_req = '0; bus.burst_len = '0; bus.ram_oe_sel = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_grants(input int n, input int budget);
        int b = 0;
        while (got_q.size() < n && b < budget) begin
            step();
            b++;
        end
        check("grant_wait", 32'(got_q.size() >= n), 32'h1);
    endtask

    task automatic score_grants(input string name);
        logic [3:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) check(name, 32'(got_q.pop_front()), 32'(e));
            else check({name, "_missing"}, 32'hFFFF, 32'(e));
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        bus.ch_req = '0; bus.burst_len = '0; bus.ram_oe_sel = 1'b0;
        step(); step();
        check("rst_ch_num", 32'(bus.ch_num), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;

        // Single request, 4-beat burst
        bus.ch_req = 16'h0001; bus.burst_len = 10'd4;
        step();
        check("t1_gnt", 32'(bus.ch_gnt), 32'h0001);
        check("t1_num", 32'(bus.ch_num), 32'h0);
        check("t1_busy", 32'(bus.busy), 32'h1);
        bus.ram_oe_sel = 1'b1;
        step(); step(); step();
        check("t1_beat3", 32'(bus.beat_cnt), 32'd3);
        check("t1_busy3", 32'(bus.busy), 32'h1);
        step();
        check("t1_rel_beat", 32'(bus.beat_cnt), 32'd4);
        check("t1_rel_gnt", 32'(bus.ch_gnt), 32'h0);
        check("t1_rel_busy", 32'(bus.busy), 32'h0);
        bus.ram_oe_sel = 1'b0; bus.ch_req = '0;
        step();
        check("t1_idle_beat", 32'(bus.beat_cnt), 32'd4);

        // All 16 requesting, single-beat bursts: 0..15 then 0
        do_reset();
        bus.ch_req = 16'hFFFF; bus.burst_len = 10'd1; bus.ram_oe_sel = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        exp_q.push_back(4'd0);
        wait_grants(17, 200);
        bus.ch_req = '0; bus.ram_oe_sel = 1'b0;
        score_grants("t2_order");
        step(); step(); step();

        // Channel 5 served, then 0x8021 -> 15, 0, 5
        do_reset();
        bus.ch_req = 16'h0020; bus.burst_len = 10'd1; bus.ram_oe_sel = 1'b1;
        wait_grants(1, 20);
        bus.ch_req = 16'h8021;
        exp_q.push_back(4'd5); exp_q.push_back(4'd15);
        exp_q.push_back(4'd0); exp_q.push_back(4'd5);
        wait_grants(4, 50);
        bus.ch_req = '0; bus.ram_oe_sel = 1'b0;
        score_grants("t3_order");
        step(); step(); step();

        // Channel 3 aborts after 2 of 8 beats
        do_reset();
        bus.ch_req = 16'h0008; bus.burst_len = 10'd8;
        wait_grants(1, 20);
        check("t4_num", 32'(bus.ch_num), 32'd3);
        bus.ram_oe_sel = 1'b1;
        step(); step();
        bus.ram_oe_sel = 1'b0; bus.ch_req = '0;
        step();
        check("t4_rel_busy", 32'(bus.busy), 32'h0);
        check("t4_rel_beat", 32'(bus.beat_cnt), 32'd2);
        check("t4_rel_terr", 32'(bus.timeout_err), 32'h0);
        bus.ch_req = 16'h0400;
        wait_grants(2, 20);
        check("t4_next_num", 32'(bus.ch_num), 32'd10);
        bus.ch_req = '0;
        step(); step(); step();

        // Watchdog: no beats after grant
        do_reset();
        bus.ch_req = 16'h0200; bus.burst_len = 10'd4;
        wait_grants(1, 20);
        for (int k = 1; k <= 1022; k++) step();
        check("t5_pre_terr", 32'(bus.timeout_err), 32'h0);
        check("t5_pre_busy", 32'(bus.busy), 32'h1);
        step();
        check("t5_terr", 32'(bus.timeout_err), 32'h1);
        check("t5_gnt", 32'(bus.ch_gnt), 32'h0);
        bus.ch_req = '0;
        step();
        check("t5_post_terr", 32'(bus.timeout_err), 32'h0);
        step(); step();

        // burst_len == 0 means 1024 beats; beat_cnt wraps to 0 at the end
        do_reset();
        bus.ch_req = 16'h0004; bus.burst_len = 10'd0;
        wait_grants(1, 20);
        bus.ram_oe_sel = 1'b1;
        for (int k = 1; k <= 1023; k++) step();
        check("t6_beat1023", 32'(bus.beat_cnt), 32'd1023);
        check("t6_busy", 32'(bus.busy), 32'h1);
        step();
        check("t6_rel_busy", 32'(bus.busy), 32'h0);
        check("t6_rel_beat", 32'(bus.beat_cnt), 32'd0);
        check("t6_rel_terr", 32'(bus.timeout_err), 32'h0);
        bus.ram_oe_sel = 1'b0; bus.ch_req = '0;
        step(); step();

        // Asynchronous reset in the middle of a burst on channel 7
        do_reset();
        bus.ch_req = 16'h0080; bus.burst_len = 10'd16;
        wait_grants(1, 20);
        bus.ram_oe_sel = 1'b1;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_gnt", 32'(bus.ch_gnt), 32'h0);
        check("t7_rst_busy", 32'(bus.busy), 32'h0);
        check("t7_rst_beat", 32'(bus.beat_cnt), 32'h0);
        check("t7_rst_num", 32'(bus.ch_num), 32'h0);
        check("t7_rst_terr", 32'(bus.timeout_err), 32'h0);
        bus.ram_oe_sel = 1'b0; bus.ch_req = 16'h0880;
        step(); step();
        got_q.delete();
        rst_n = 1'b1;
        exp_q.push_back(4'd7);
        wait_grants(1, 20);
        score_grants("t7_first");
        bus.ch_req = '0;
        step(); step(); step();

        // Random traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if ($urandom_range(0, 9) == 0)
                bus.ch_req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            bus.ram_oe_sel = ($urandom_range(0, 9) < 6);
            bus.burst_len  = 10'($urandom_range(1, 5));
        end
        bus.ch_req = '0; bus.ram_oe_sel = 1'b0;
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ram_ch_arb.md
Name: ram_ch_arb

Overview:
- Round-robin arbiter that decides which of 16 flash channels owns the shared page-buffer RAM read port.
- Drives the 4-bit channel select consumed by the RAM output-enable channel mux (ram_ch) and one-hot grants back to the channels.
- Counts data beats on the muxed output-enable returned from ram_ch, closes each burst at a latched length, and recovers from stalled or abandoned bursts with a watchdog.

Parameters:
- NUM_CH, 16, number of channels; fixed to 16 so it matches the 4-bit mux select.
- CH_W, 4, width of ch_num.
- BURST_W, 10, width of the burst length and the beat counter.
- TIMEOUT, 1023, maximum idle cycles between beats inside a burst before forced release.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_req  in  16  per-channel RAM access request, level; bit i belongs to channel i.
- burst_len  in  BURST_W  beats per burst; latched at grant.
- ram_oe_sel  in  1  muxed output-enable from ram_ch; each high cycle is one beat.
- ch_num  out  CH_W  selected channel index; drives the ram_ch select.
- ch_gnt  out  16  one-hot grant to the owning channel.
- busy  out  1  high while a burst is owned (GRANT state).
- beat_cnt  out  BURST_W  beats completed in the current burst.
- timeout_err  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset values: ch_num=0, ch_gnt=0, busy=0, beat_cnt=0, timeout_err=0, state=IDLE, last_ptr=NUM_CH-1 (so channel 0 has top priority after reset), wd_cnt=0.
- All outputs are registered.
- States:
  - IDLE: if ch_req!=0, pick the first set bit searching upward from last_ptr+1 mod 16. Next cycle: GRANT, ch_num=winner, ch_gnt=1<<winner, busy=1, beat_cnt=0, len_q=burst_len. Arbitration latency is 1 cycle from request to grant. If ch_req==0, stay in IDLE.
  - GRANT:
    - A cycle with ram_oe_sel=1 increments beat_cnt and clears wd_cnt.
    - A cycle with ram_oe_sel=0 increments wd_cnt.
    - Go to RELEASE when a beat arrives with beat_cnt==len_q-1 (the burst completes on the final beat).
  - RELEASE: lasts exactly 1 cycle. ch_gnt=0, busy=0, last_ptr=ch_num, ch_num holds its value, beat_cnt holds its final count. Next state is IDLE. This guarantees at least one dead cycle between grants, so two channels never see overlapping grants.
- Early exits from GRANT:
  - Abort: ch_req[ch_num]=0 during GRANT -> RELEASE next cycle; beat_cnt holds the partial count.
  - Watchdog: wd_cnt reaching TIMEOUT -> RELEASE, with timeout_err=1 for that single cycle.
- Same-cycle priority inside GRANT: final beat > abort > watchdog. A final beat in the same cycle as a request drop is a normal completion, not an abort, and raises no error.
- Width rules:
  - len_q==0 is treated as 2^BURST_W beats.
  - beat_cnt wraps modulo 2^BURST_W; only the terminal compare ends the burst.
  - wd_cnt is wide enough to hold TIMEOUT and saturates there.
- Round-robin fairness: a channel that held the last grant is searched last. With all 16 requesting, grants go 0,1,...,15,0 in order.
- ram_oe_sel outside GRANT is ignored.
- ch_req bits change freely; only the owner's bit matters during GRANT.
- ch_num holds its value in IDLE and RELEASE so the mux select never glitches.
- Reset mid-burst: asynchronous return to the reset values; the next grant goes to the lowest requesting index.

Decomposition:
- Shared package ssd_ctrl_pkg holds:
  - NUM_CH and CH_W constants;
  - state enum {IDLE, GRANT, RELEASE};
  - burst length type.
- Natural sub-module: rr_pick16, the combinational round-robin priority picker (inputs req[15:0] and last_ptr; outputs winner index and a valid flag).
- The FSM, beat counter and watchdog stay in ram_ch_arb.

Test Plan:
- Reset release, then ch_req=0x0001, burst_len=4, four ram_oe_sel pulses -> ch_gnt=0x0001 and ch_num=0 one cycle after the request. Release comes on the cycle after the 4th beat with beat_cnt=4, then busy=0.
- ch_req=0xFFFF held, burst_len=1, one beat per grant -> grant order 0,1,2,...,15,0, each grant separated by one RELEASE cycle, with ch_gnt always one-hot or zero.
- After channel 5 has been served, ch_req=0x8021 -> next grant goes to channel 15, then 0, then 5.
- Granted channel 3 with burst_len=8 drops its request after 2 beats -> RELEASE next cycle, beat_cnt=2, timeout_err stays 0, then the arbiter serves the next requester.
- Grant given and ram_oe_sel held low with TIMEOUT=1023 -> timeout_err pulses for one cycle 1023 cycles after the grant, with ch_gnt=0 in that same cycle.
- rst_n asserted mid-burst on channel 7 -> all outputs return to reset values immediately (asynchronously). After release with ch_req=0x0880, the first grant goes to channel 7.
